// File: rtl/mem_port_b_arbiter.sv
// ============================================================================
// Module   : mem_port_b_arbiter
// Purpose  : Shares port B of the 1K x 16 program/data memory between the VGA
//            read requester and the I/O writer, one access per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_b_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rr_mode,
    input  logic        vga_req,
    input  logic [9:0]  vga_addr,
    output logic        vga_gnt,
    output logic        vga_rvalid,
    output logic [15:0] vga_rdata,
    input  logic        io_req,
    input  logic        io_we,
    input  logic [9:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic        io_gnt,
    output logic        io_rvalid,
    output logic [15:0] io_rdata,
    output logic [9:0]  addr_b,
    output logic [15:0] data_b,
    output logic        w_en_b,
    input  logic [15:0] mem_out_b
);

    localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       r_last_io;
    logic [9:0] r_addr_b;
    logic       r_vga_rvalid;
    logic       r_io_rvalid;

    logic       w_io_wins;
    logic       w_vga_gnt;
    logic       w_io_gnt;
    logic [9:0] w_addr_b;

    // Tie-break: round-robin favours whoever did not win last; fixed mode
    // lets I/O through only once it has waited STARVE_LIMIT cycles.
    always_comb begin
        w_io_wins = rr_mode ? ~r_last_io : (r_starve_cnt == c_limit);
        w_vga_gnt = 1'b0;
        w_io_gnt  = 1'b0;
        if (!reset) begin
            if (vga_req && io_req) begin
                w_vga_gnt = ~w_io_wins;
                w_io_gnt  = w_io_wins;
            end else begin
                w_vga_gnt = vga_req;
                w_io_gnt  = io_req;
            end
        end
    end

    always_comb begin
        w_addr_b = r_addr_b;
        if (reset) begin
            w_addr_b = 10'd0;
        end else if (w_vga_gnt) begin
            w_addr_b = vga_addr;
        end else if (w_io_gnt) begin
            w_addr_b = io_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
            r_last_io    <= 1'b1;
            r_addr_b     <= 10'd0;
            r_vga_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
        end else begin
            r_addr_b     <= w_addr_b;
            r_vga_rvalid <= w_vga_gnt;
            r_io_rvalid  <= w_io_gnt & ~io_we;
            if (w_vga_gnt || w_io_gnt) begin
                r_last_io <= w_io_gnt;
            end
            if (rr_mode || !io_req || w_io_gnt) begin
                r_starve_cnt <= 8'd0;
            end else if (r_starve_cnt != c_limit) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    assign vga_gnt = w_vga_gnt;
    assign io_gnt  = w_io_gnt;
    assign addr_b  = w_addr_b;
    assign data_b  = io_wdata;
    assign w_en_b  = w_io_gnt & io_we;

    // A read return in flight when reset hits is suppressed immediately.
    assign vga_rvalid = r_vga_rvalid & ~reset;
    assign io_rvalid  = r_io_rvalid & ~reset;
    assign vga_rdata  = mem_out_b;
    assign io_rdata   = mem_out_b;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_b_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_b_arbiter
// Purpose  : Directed and randomized bench for mem_port_b_arbiter against a
//            behavioural arbiter/memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_b_arbiter;

    localparam int LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rr_mode;
    logic        vga_req, io_req, io_we;
    logic [9:0]  vga_addr, io_addr;
    logic [15:0] io_wdata;
    logic        vga_gnt, io_gnt, vga_rvalid, io_rvalid, w_en_b;
    logic [15:0] vga_rdata, io_rdata, data_b, mem_out_b;
    logic [9:0]  addr_b;

    logic        d1_rr_mode, d1_vga_req, d1_io_req, d1_io_we;
    logic [9:0]  d1_vga_addr, d1_io_addr;
    logic [15:0] d1_io_wdata, d1_mem_out_b;
    logic        d1_vga_gnt, d1_io_gnt, d1_vga_rvalid, d1_io_rvalid, d1_w_en_b;
    logic [15:0] d1_vga_rdata, d1_io_rdata, d1_data_b;
    logic [9:0]  d1_addr_b;

    mem_port_b_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .rr_mode(rr_mode),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .addr_b(addr_b), .data_b(data_b), .w_en_b(w_en_b), .mem_out_b(mem_out_b)
    );

    mem_port_b_arbiter #(.STARVE_LIMIT(1)) dut1 (
        .clk(clk), .reset(reset), .rr_mode(d1_rr_mode),
        .vga_req(d1_vga_req), .vga_addr(d1_vga_addr), .vga_gnt(d1_vga_gnt),
        .vga_rvalid(d1_vga_rvalid), .vga_rdata(d1_vga_rdata),
        .io_req(d1_io_req), .io_we(d1_io_we), .io_addr(d1_io_addr), .io_wdata(d1_io_wdata),
        .io_gnt(d1_io_gnt), .io_rvalid(d1_io_rvalid), .io_rdata(d1_io_rdata),
        .addr_b(d1_addr_b), .data_b(d1_data_b), .w_en_b(d1_w_en_b), .mem_out_b(d1_mem_out_b)
    );

    // Synchronous 1K x 16 memory on port B.
    logic [15:0] tmem [0:1023];
    logic [15:0] mem_q;
    always @(posedge clk) begin
        if (w_en_b) tmem[addr_b] <= data_b;
        mem_q <= tmem[addr_b];
    end
    assign mem_out_b = mem_q;

    // Reference model state.
    int          m_starve;
    bit          m_last_io;
    logic [9:0]  m_addr;
    bit          m_vrv, m_irv, m_vrk, m_irk;
    logic [15:0] m_vrd, m_ird;
    logic [15:0] ref_mem [1024];
    bit          ref_ok  [1024];

    int n_vec = 0;
    int n_err = 0;
    bit e_vg, e_ig;
    bit o_vg, o_ig, o_we, o_vrv, o_irv;
    logic [15:0] o_vrd, o_ird;
    bit chk1, e1_v, e1_i;
    logic [9:0] seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, sample mid-cycle, then advance the model.
    task automatic step();
        bit ev, ei, io_first;
        logic [9:0] ea;
        ev = 1'b0;
        ei = 1'b0;
        if (!reset) begin
            if (vga_req && io_req) begin
                io_first = rr_mode ? !m_last_io : (m_starve == LIMIT);
                ev = !io_first;
                ei = io_first;
            end else begin
                ev = vga_req;
                ei = io_req;
            end
        end
        ea = reset ? 10'd0 : (ev ? vga_addr : (ei ? io_addr : m_addr));
        #3;
        chk("vga_gnt", 32'(vga_gnt), 32'(ev));
        chk("io_gnt", 32'(io_gnt), 32'(ei));
        chk("addr_b", 32'(addr_b), 32'(ea));
        chk("w_en_b", 32'(w_en_b), 32'(ei && io_we));
        chk("data_b", 32'(data_b), 32'(io_wdata));
        chk("vga_rvalid", 32'(vga_rvalid), 32'(m_vrv && !reset));
        chk("io_rvalid", 32'(io_rvalid), 32'(m_irv && !reset));
        if (m_vrv && !reset && m_vrk) chk("vga_rdata", 32'(vga_rdata), 32'(m_vrd));
        if (m_irv && !reset && m_irk) chk("io_rdata", 32'(io_rdata), 32'(m_ird));
        if (chk1) begin
            chk("lim1_vga_gnt", 32'(d1_vga_gnt), 32'(e1_v));
            chk("lim1_io_gnt", 32'(d1_io_gnt), 32'(e1_i));
        end
        o_vg = vga_gnt; o_ig = io_gnt; o_we = w_en_b;
        o_vrv = vga_rvalid; o_irv = io_rvalid;
        o_vrd = vga_rdata; o_ird = io_rdata;
        e_vg = ev; e_ig = ei;

        m_vrv = ev;
        m_irv = ei && !io_we;
        if (ev) begin m_vrd = ref_mem[vga_addr]; m_vrk = ref_ok[vga_addr]; end
        if (ei && !io_we) begin m_ird = ref_mem[io_addr]; m_irk = ref_ok[io_addr]; end
        if (ei && io_we) begin ref_mem[io_addr] = io_wdata; ref_ok[io_addr] = 1'b1; end
        if (reset) begin
            m_starve = 0; m_last_io = 1'b1; m_addr = 10'd0;
        end else begin
            m_addr = ea;
            if (rr_mode || !io_req || ei) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (ev) m_last_io = 1'b0;
            if (ei) m_last_io = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rr_mode = 1'b0;
        vga_req = 1'b1; vga_addr = 10'h055;
        io_req = 1'b1; io_we = 1'b1; io_addr = 10'h2AA; io_wdata = 16'h1111;
        d1_rr_mode = 1'b0; d1_vga_req = 1'b0; d1_io_req = 1'b0; d1_io_we = 1'b0;
        d1_vga_addr = 10'd0; d1_io_addr = 10'd0; d1_io_wdata = 16'd0; d1_mem_out_b = 16'd0;
        chk1 = 1'b0; e1_v = 1'b0; e1_i = 1'b0;
        m_starve = 0; m_last_io = 1'b1; m_addr = 10'd0;
        m_vrv = 1'b0; m_irv = 1'b0; m_vrk = 1'b0; m_irk = 1'b0;
        m_vrd = 16'd0; m_ird = 16'd0;
        for (int i = 0; i < 1024; i++) begin ref_ok[i] = 1'b0; ref_mem[i] = 16'd0; end
        @(posedge clk);
        #1;

        // Requests during reset are never granted.
        step();
        step();

        // Load 0x1234 at 0x010, then a VGA read of it.
        reset = 1'b0; vga_req = 1'b0;
        io_addr = 10'h010; io_wdata = 16'h1234;
        step();
        io_req = 1'b0; vga_req = 1'b1; vga_addr = 10'h010;
        step();
        chk("tp1_vga_gnt", 32'(o_vg), 32'd1);
        vga_req = 1'b0;
        step();
        chk("tp1_vga_rvalid", 32'(o_vrv), 32'd1);
        chk("tp1_vga_rdata", 32'(o_vrd), 32'h1234);

        // I/O write then read-back at the top address.
        io_req = 1'b1; io_we = 1'b1; io_addr = 10'h3FF; io_wdata = 16'hBEEF;
        step();
        chk("tp2_w_en_b", 32'(o_we), 32'd1);
        io_we = 1'b0;
        step();
        io_req = 1'b0;
        step();
        chk("tp2_io_rvalid", 32'(o_irv), 32'd1);
        chk("tp2_io_rdata", 32'(o_ird), 32'hBEEF);

        // Fixed priority with VGA saturating: I/O gets cycle 8.
        seq = 10'd0;
        vga_req = 1'b1; io_req = 1'b1; io_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            vga_addr = 10'(k);
            if (k == 9) io_req = 1'b0;
            step();
            seq[k] = o_ig;
        end
        chk("starve_seq", 32'(seq), 32'h100);

        // Round-robin from reset: VGA first, then alternate.
        reset = 1'b1; vga_req = 1'b0; io_req = 1'b0;
        step();
        reset = 1'b0; rr_mode = 1'b1;
        vga_req = 1'b1; io_req = 1'b1; io_we = 1'b1;
        io_addr = 10'h020; io_wdata = 16'hA5A5;
        seq = 10'd0;
        for (int k = 0; k < 6; k++) begin
            vga_addr = 10'(k + 32);
            step();
            seq[k] = o_vg;
        end
        chk("rr_seq", 32'(seq), 32'h015);

        // Reset right after a VGA read grant drops its rvalid.
        rr_mode = 1'b0; io_req = 1'b0; vga_req = 1'b1; vga_addr = 10'h010;
        step();
        vga_req = 1'b0; reset = 1'b1;
        step();
        chk("rst_vga_rvalid", 32'(o_vrv), 32'd0);
        reset = 1'b0; vga_req = 1'b1; io_req = 1'b1; io_we = 1'b0; io_addr = 10'h3FF;
        step();
        chk("post_rst_vga_wins", 32'(o_vg), 32'd1);
        vga_req = 1'b0;
        step();
        io_req = 1'b0;
        step();

        // STARVE_LIMIT=1 alternates even in fixed-priority mode.
        d1_vga_req = 1'b1; d1_io_req = 1'b1; chk1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e1_v = (k % 2 == 0);
            e1_i = !e1_v;
            step();
        end
        chk1 = 1'b0; d1_vga_req = 1'b0; d1_io_req = 1'b0;

        // Randomized traffic; requesters hold until granted.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(63) == 0);
            if ($urandom_range(15) == 0) rr_mode = 1'($urandom_range(1));
            if (!vga_req || e_vg) begin
                vga_req  = ($urandom_range(3) != 0);
                vga_addr = 10'($urandom_range(15));
            end
            if (!io_req || e_ig) begin
                io_req   = 1'($urandom_range(1));
                io_we    = 1'($urandom_range(1));
                io_addr  = 10'($urandom_range(15));
                io_wdata = 16'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_b_arbiter.md
# mem_port_b_arbiter

Arbiter for the second (B) port of the shared 1K x 16 program/data memory. Port A stays owned by the CPU fetch/load/store path; port B is shared between the VGA read requester and the I/O writer (SNES button-state snooper / debug loader). The block grants one access per cycle, drives the port-B address, write-enable and write-data, and returns tagged read-valid strobes one cycle later to match the synchronous memory read latency.

## Interface
- STARVE_LIMIT, 8: consecutive denied cycles after which a waiting I/O request beats VGA in fixed-priority mode; legal 1..255.
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- rr_mode  in  1  0 = VGA-first with starvation guard, 1 = round-robin; sampled every cycle.
- vga_req  in  1  VGA read request; held with vga_addr stable until vga_gnt.
- vga_addr  in  10  VGA read address.
- vga_gnt  out  1  combinational grant to VGA, same cycle as the accepted request.
- vga_rvalid  out  1  registered; vga_rdata is valid this cycle.
- vga_rdata  out  16  read data, driven directly from mem_out_b.
- io_req  in  1  I/O request; held with io_we/io_addr/io_wdata stable until io_gnt.
- io_we  in  1  1 = write, 0 = read.
- io_addr  in  10  I/O address.
- io_wdata  in  16  I/O write data.
- io_gnt  out  1  combinational grant to I/O.
- io_rvalid  out  1  registered; io_rdata valid this cycle (reads only).
- io_rdata  out  16  read data, driven directly from mem_out_b.
- addr_b  out  10  memory port-B address.
- data_b  out  16  memory port-B write data (= io_wdata).
- w_en_b  out  1  memory port-B write enable.
- mem_out_b  in  16  memory port-B read data, valid one cycle after addr_b.

## Operation
- At most one of vga_gnt/io_gnt high per cycle; a grant requires the matching req.
- During reset: vga_gnt, io_gnt, w_en_b forced 0; addr_b = 0.
- Only requester asking: granted immediately.
- Both asking, rr_mode=0: VGA wins unless starve_cnt == STARVE_LIMIT, then I/O wins.
- Both asking, rr_mode=1: the requester not granted last wins; last_winner updates on every grant (including uncontended ones).
- starve_cnt (8-bit): increments by 1 on each cycle io_req=1 and io_gnt=0 while rr_mode=0, saturating at STARVE_LIMIT; clears to 0 on io_gnt, on io_req=0, or whenever rr_mode=1.
- addr_b = granted requester's address; when nothing is granted, addr_b holds the last granted address (no spurious change).
- w_en_b = io_gnt & io_we; data_b = io_wdata always. VGA never writes.
- Read return: vga_rvalid <= vga_gnt; io_rvalid <= io_gnt & ~io_we. The rdata outputs are mem_out_b unqualified; consumers qualify them with rvalid.
- Requester rule: after a grant, the requester presents the next request (or drops req) in the following cycle. Back-to-back grants to the same requester on consecutive cycles are legal.

## Timing
- Reset values: vga_gnt=0, io_gnt=0, vga_rvalid=0, io_rvalid=0, w_en_b=0, addr_b=0, starve_cnt=0, last_winner=I/O (VGA wins the first round-robin tie).
- Grant latency: 0 cycles (combinational from req and state). Read latency: rvalid exactly 1 cycle after the grant. Write: committed at the end of the grant cycle.
- Throughput: 1 access/cycle total.
- Worst-case I/O wait in mode 0 with VGA saturating: STARVE_LIMIT denied cycles, then a grant on the next cycle.
- Reset asserted the cycle after a read grant: the pending rvalid is dropped (0 the next cycle).
- rr_mode toggling mid-contention: takes effect in the same cycle; starve_cnt clears when entering mode 1.

## Test plan
- Reset, then vga_req=1 with addr 0x010 (memory holds 0x1234) -> vga_gnt=1 that cycle, addr_b=0x010; next cycle vga_rvalid=1, vga_rdata=0x1234.
- io_req=1, io_we=1, addr 0x3FF, wdata 0xBEEF, no VGA -> io_gnt=1, w_en_b=1 one cycle; then an I/O read of 0x3FF -> io_rvalid=1 with 0xBEEF one cycle after its grant.
- rr_mode=0, vga_req held high, io_req high from cycle 0, STARVE_LIMIT=8 -> VGA granted cycles 0-7; io_gnt in cycle 8; VGA resumes in cycle 9; starve_cnt=0.
- rr_mode=1, both requesting continuously -> grants alternate starting VGA, I/O, VGA, I/O...; w_en_b is never high on a VGA cycle.
- VGA read granted, reset asserted in the next cycle -> vga_rvalid=0, all grants 0, addr_b=0; after reset a contended request goes to VGA.
- STARVE_LIMIT=1 with contention -> VGA, I/O, VGA, I/O alternation in mode 0.
